gpr_file: RTL
=============

Name: gpr_file

Overview:
- RV32 general-purpose register file for the single-cycle NPC core.
- Provides two combinational read ports and one write-back port, with x0 hardwired to zero.
- Exports all 32 architectural registers, a retire counter and a snapshot strobe to the downstream register-display/difftest stage, which calls into the simulator.
- Sits between the writeback mux, the decode/execute read path and the display stage.

Parameters:
- XLEN, 32, data width of each register.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding on the read ports; 0 = reads return stored value only.

Ports:
- clock  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rs1_addr  input  5  read port 1 index.
- rs1_data  output  XLEN  read port 1 data.
- rs2_addr  input  5  read port 2 index.
- rs2_data  output  XLEN  read port 2 data.
- wen  input  1  write enable from writeback.
- rd_addr  input  5  write index.
- rd_data  input  XLEN  write data.
- commit_valid  input  1  current instruction retires this cycle; low = stalled.
- instret  output  64  count of retired instructions.
- snap_valid  output  1  one-cycle strobe: regs_N now reflect a just-retired instruction.
- regs_0 .. regs_31  output  XLEN each  architectural register contents, driven from storage (regs_0 constant 0).

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - x1..x31 = 0, instret = 0, snap_valid = 0.
  - Any write in the same cycle is discarded.
- Write:
  - At a rising edge, reg[rd_addr] <= rd_data only if wen && commit_valid && rd_addr != 0.
  - wen with commit_valid low (stall) performs no write.
  - A write to x0 is silently dropped; x0 always reads 0.
- Read (combinational, zero latency):
  - rsN_data = 0 if rsN_addr == 0.
  - Else, if BYPASS=1 and wen && commit_valid && rd_addr == rsN_addr, rsN_data = rd_data.
  - Else rsN_data = stored reg[rsN_addr].
  - Both ports may address the same register; each resolves independently.
- regs_N outputs:
  - Never bypassed; they show the stored state.
  - They change exactly one edge after the write.
- instret:
  - Increments by 1 at every rising edge with commit_valid = 1, regardless of wen.
  - Wraps 2^64-1 -> 0 with no flag.
- snap_valid:
  - Registered copy of commit_valid, so it is high in the cycle after the retiring edge.
  - In that cycle regs_N and instret both include the retired instruction's effects.
  - Back-to-back commits keep snap_valid high continuously.
  - The display stage samples regs_N only while snap_valid = 1.
- Simultaneous events:
  - Write and read of the same index in one cycle: bypass rules above apply.
  - Reset asserted together with commit_valid: reset wins; no increment, no write, snap_valid stays 0.
- No X propagation: every register has a defined reset value; no latches.

Test Plan:
- Reset then idle -> rs1_data = rs2_data = 0 for all 32 addresses; regs_0..31 = 0; instret = 0; snap_valid = 0.
- wen=1, commit_valid=1, rd=5, rd_data=0xDEADBEEF, rs1=5 in the same cycle:
  - BYPASS=1 -> rs1_data = 0xDEADBEEF combinationally; BYPASS=0 -> rs1_data = 0.
  - Next cycle -> regs_5 = 0xDEADBEEF, snap_valid = 1, instret = 1.
- Write rd=0, data=0x12345678 -> rs1 = 0 reads 0 and regs_0 = 0; instret still increments; snap_valid pulses.
- wen=1, commit_valid=0, rd=7, data=0xA5A5A5A5 -> regs_7 unchanged (0); instret unchanged; snap_valid = 0 next cycle.
- 3 consecutive commits writing x1 = 1, 2, 3 -> snap_valid high for 3 cycles; regs_1 sequence 1, 2, 3; instret ends at 3.
- Preload instret near wrap via 2^64-1 commits (bench-forced), then one more commit -> instret = 0. Separately, assert reset mid-cycle after writing x10 = 0xFF -> regs_10 = 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/gpr_file.sv
// RV32 general-purpose register file: two combinational read ports, one write-back port,
// x0 hardwired to zero, plus retire counter and snapshot strobe for the display stage.
module gpr_file #(
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [4:0]      rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wen,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            commit_valid,
    output logic [63:0]     instret,
    output logic            snap_valid,
    output logic [XLEN-1:0] regs_0,
    output logic [XLEN-1:0] regs_1,
    output logic [XLEN-1:0] regs_2,
    output logic [XLEN-1:0] regs_3,
    output logic [XLEN-1:0] regs_4,
    output logic [XLEN-1:0] regs_5,
    output logic [XLEN-1:0] regs_6,
    output logic [XLEN-1:0] regs_7,
    output logic [XLEN-1:0] regs_8,
    output logic [XLEN-1:0] regs_9,
    output logic [XLEN-1:0] regs_10,
    output logic [XLEN-1:0] regs_11,
    output logic [XLEN-1:0] regs_12,
    output logic [XLEN-1:0] regs_13,
    output logic [XLEN-1:0] regs_14,
    output logic [XLEN-1:0] regs_15,
    output logic [XLEN-1:0] regs_16,
    output logic [XLEN-1:0] regs_17,
    output logic [XLEN-1:0] regs_18,
    output logic [XLEN-1:0] regs_19,
    output logic [XLEN-1:0] regs_20,
    output logic [XLEN-1:0] regs_21,
    output logic [XLEN-1:0] regs_22,
    output logic [XLEN-1:0] regs_23,
    output logic [XLEN-1:0] regs_24,
    output logic [XLEN-1:0] regs_25,
    output logic [XLEN-1:0] regs_26,
    output logic [XLEN-1:0] regs_27,
    output logic [XLEN-1:0] regs_28,
    output logic [XLEN-1:0] regs_29,
    output logic [XLEN-1:0] regs_30,
    output logic [XLEN-1:0] regs_31
);

    // Entry 0 is reset to zero and never written, so it doubles as the x0 constant.
    logic [XLEN-1:0] regs_r [0:31];
    logic [63:0]     instret_r;
    logic            snap_r;
    logic            fwd_s;
    logic            do_write_s;

    assign fwd_s      = wen && commit_valid;
    assign do_write_s = fwd_s && (rd_addr != 5'd0);

    // Architectural register storage with write-back port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (do_write_s) begin
            regs_r[rd_addr] <= rd_data;
        end
    end

    // Retire counter and snapshot strobe (strobe follows the retiring edge by one cycle).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instret_r <= 64'd0;
            snap_r    <= 1'b0;
        end else begin
            if (commit_valid) begin
                instret_r <= instret_r + 64'd1;
            end
            snap_r <= commit_valid;
        end
    end

    // Read port 1: x0 first, then optional same-cycle forwarding, then storage.
    always_comb begin
        rs1_data = {XLEN{1'b0}};
        if (rs1_addr == 5'd0) begin
            rs1_data = {XLEN{1'b0}};
        end else if ((BYPASS == 1'b1) && fwd_s && (rd_addr == rs1_addr)) begin
            rs1_data = rd_data;
        end else begin
            rs1_data = regs_r[rs1_addr];
        end
    end

    // Read port 2: resolved independently of port 1.
    always_comb begin
        rs2_data = {XLEN{1'b0}};
        if (rs2_addr == 5'd0) begin
            rs2_data = {XLEN{1'b0}};
        end else if ((BYPASS == 1'b1) && fwd_s && (rd_addr == rs2_addr)) begin
            rs2_data = rd_data;
        end else begin
            rs2_data = regs_r[rs2_addr];
        end
    end

    assign instret    = instret_r;
    assign snap_valid = snap_r;

    // Display exports come straight from storage and are never forwarded.
    assign regs_0  = regs_r[0];
    assign regs_1  = regs_r[1];
    assign regs_2  = regs_r[2];
    assign regs_3  = regs_r[3];
    assign regs_4  = regs_r[4];
    assign regs_5  = regs_r[5];
    assign regs_6  = regs_r[6];
    assign regs_7  = regs_r[7];
    assign regs_8  = regs_r[8];
    assign regs_9  = regs_r[9];
    assign regs_10 = regs_r[10];
    assign regs_11 = regs_r[11];
    assign regs_12 = regs_r[12];
    assign regs_13 = regs_r[13];
    assign regs_14 = regs_r[14];
    assign regs_15 = regs_r[15];
    assign regs_16 = regs_r[16];
    assign regs_17 = regs_r[17];
    assign regs_18 = regs_r[18];
    assign regs_19 = regs_r[19];
    assign regs_20 = regs_r[20];
    assign regs_21 = regs_r[21];
    assign regs_22 = regs_r[22];
    assign regs_23 = regs_r[23];
    assign regs_24 = regs_r[24];
    assign regs_25 = regs_r[25];
    assign regs_26 = regs_r[26];
    assign regs_27 = regs_r[27];
    assign regs_28 = regs_r[28];
    assign regs_29 = regs_r[29];
    assign regs_30 = regs_r[30];
    assign regs_31 = regs_r[31];

endmodule
